// File: rtl/gyro_frame_pkg.sv
// Shared types and frame layout for the gyro frame packetizer.
// GYRO_FRAME_TEMP_EN adds the temperature word to the payload.
package gyro_frame_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_LO,
      WAIT_HI
   } state_t;

   localparam logic [7:0] DEF_SYNC0 = 8'hA5;
   localparam logic [7:0] DEF_SYNC1 = 8'h5A;

   localparam logic [3:0] IDX_SYNC0 = 4'd0;
   localparam logic [3:0] IDX_SYNC1 = 4'd1;
   localparam logic [3:0] IDX_SEQ   = 4'd2;
   localparam logic [3:0] IDX_PAY   = 4'd3;

`ifdef GYRO_FRAME_TEMP_EN
   localparam int PAY_BYTES = 8;
`else
   localparam int PAY_BYTES = 6;
`endif

   localparam int PAY_W = 8 * PAY_BYTES;
   localparam int FRAME_LEN = PAY_BYTES + 4;
   localparam logic [3:0] IDX_CHK = 4'(FRAME_LEN - 1);

   // Bytes covered by the checksum: SEQ through the last payload byte.
   function automatic logic in_sum(input logic [3:0] idx);
      return (idx >= IDX_SEQ) && (idx < IDX_CHK);
   endfunction

endpackage

// File: rtl/gyro_frame_byte_mux.sv
// Selects the frame byte at the current index.
// Payload is packed little-endian, X low byte at bit 0.
import gyro_frame_pkg::*;

module gyro_frame_byte_mux #(
   parameter logic [7:0] SYNC0 = DEF_SYNC0,
   parameter logic [7:0] SYNC1 = DEF_SYNC1
) (
   input  logic [3:0]       idx,
   input  logic [PAY_W-1:0] payload,
   input  logic [7:0]       seq,
   input  logic [7:0]       chk,
   output logic [7:0]       data
);

   logic [3:0]       k;
   logic [PAY_W-1:0] sh;

   assign k  = idx - IDX_PAY;
   assign sh = payload >> {k, 3'b000};

   always_comb begin
      data = sh[7:0];
      unique case (1'b1)
         (idx == IDX_SYNC0): data = SYNC0;
         (idx == IDX_SYNC1): data = SYNC1;
         (idx == IDX_SEQ):   data = seq;
         (idx == IDX_CHK):   data = chk;
         default:            data = sh[7:0];
      endcase
   end

endmodule

// File: rtl/gyro_frame_tx.sv
// Gyro axis packetizer feeding UART_TX via start/ready handshake.
// Define GYRO_FRAME_TEMP_EN to append the temperature word to each frame.
import gyro_frame_pkg::*;

module gyro_frame_tx #(
   parameter logic [7:0] SYNC0 = DEF_SYNC0,
   parameter logic [7:0] SYNC1 = DEF_SYNC1,
   parameter int         DECIM = 1
) (
   input  logic        GCLK,
   input  logic        RST,
   input  logic        enable,
   input  logic        sample_valid,
   input  logic [15:0] x_axis_data,
   input  logic [15:0] y_axis_data,
   input  logic [15:0] z_axis_data,
   input  logic [15:0] temp_data,
   input  logic        tx_ready,
   output logic [7:0]  tx_data,
   output logic        tx_start,
   output logic        busy,
   output logic        frame_done,
   output logic [7:0]  seq,
   output logic [7:0]  drop_count
);

   localparam logic [7:0] DECIM_M1 = 8'(DECIM - 1);

   state_t           state, state_n;
   logic [7:0]       dcnt;
   logic [3:0]       idx;
   logic [7:0]       chk;
   logic [7:0]       data_q;
   logic [7:0]       byte_val;
   logic [PAY_W-1:0] snap;
   logic             sel;

`ifndef GYRO_FRAME_TEMP_EN
   logic unused_temp;
   assign unused_temp = ^temp_data;
`endif

   assign sel  = sample_valid && enable && (dcnt == DECIM_M1);
   assign busy = (state != IDLE);
   // Live byte on the issue cycle, otherwise the last issued byte.
   assign tx_data = tx_start ? byte_val : data_q;

   gyro_frame_byte_mux #(
      .SYNC0 (SYNC0),
      .SYNC1 (SYNC1)
   ) u_mux (
      .idx     (idx),
      .payload (snap),
      .seq     (seq),
      .chk     (chk),
      .data    (byte_val)
   );

   always_ff @(posedge GCLK) begin
      if (RST) begin
         state      <= IDLE;
         dcnt       <= '0;
         idx        <= IDX_SYNC0;
         chk        <= '0;
         data_q     <= '0;
         snap       <= '0;
         seq        <= '0;
         drop_count <= '0;
      end else begin
         state <= state_n;
         if (sample_valid && enable)
            dcnt <= sel ? 8'd0 : dcnt + 8'd1;
         if (sel && state == IDLE) begin
`ifdef GYRO_FRAME_TEMP_EN
            snap <= {temp_data, z_axis_data, y_axis_data, x_axis_data};
`else
            snap <= {z_axis_data, y_axis_data, x_axis_data};
`endif
            idx <= IDX_SYNC0;
            chk <= '0;
         end
         if (sel && state != IDLE && drop_count != 8'hFF)
            drop_count <= drop_count + 8'd1;
         if (tx_start) begin
            data_q <= byte_val;
            if (in_sum(idx))
               chk <= chk + byte_val;
         end
         if (state == WAIT_HI && tx_ready && idx != IDX_CHK)
            idx <= idx + 4'd1;
         if (frame_done)
            seq <= seq + 8'd1;
      end
   end

   always_comb begin
      state_n    = state;
      tx_start   = 1'b0;
      frame_done = 1'b0;
      unique case (state)
         IDLE: begin
            if (sel)
               state_n = SEND;
         end
         SEND: begin
            if (tx_ready) begin
               tx_start = 1'b1;
               state_n  = WAIT_LO;
            end
         end
         WAIT_LO: begin
            if (!tx_ready)
               state_n = WAIT_HI;
         end
         WAIT_HI: begin
            if (tx_ready) begin
               if (idx == IDX_CHK) begin
                  frame_done = 1'b1;
                  state_n    = IDLE;
               end else begin
                  state_n = SEND;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

endmodule

// File: tb/tb_gyro_frame_tx.sv
// Directed bench for gyro_frame_tx with a simple UART_TX ready model.
// Runs one DECIM=1 instance and one DECIM=3 instance on shared inputs.
module tb_gyro_frame_tx;

   localparam int N_BUSY = 3;

   logic        GCLK = 1'b0;
   logic        RST = 1'b1;
   logic        enable = 1'b0;
   logic        sample_valid = 1'b0;
   logic [15:0] x = '0;
   logic [15:0] y = '0;
   logic [15:0] z = '0;
   logic [15:0] t = '0;

   logic       tx_ready1, tx_ready3;
   logic [7:0] tx_data1, tx_data3;
   logic       tx_start1, tx_start3;
   logic       busy1, busy3;
   logic       done1, done3;
   logic [7:0] seq1, seq3;
   logic [7:0] drop1, drop3;

   logic       hold1 = 1'b0;
   int         bc1 = 0;
   int         bc3 = 0;

   logic [7:0] cap[$];
   int         n_start = 0;
   int         n_done = 0;
   int         n_done3 = 0;

   int n_tests = 0;
   int n_fail = 0;

   always #5 GCLK = ~GCLK;

   gyro_frame_tx u_dut1 (
      .GCLK         (GCLK),
      .RST          (RST),
      .enable       (enable),
      .sample_valid (sample_valid),
      .x_axis_data  (x),
      .y_axis_data  (y),
      .z_axis_data  (z),
      .temp_data    (t),
      .tx_ready     (tx_ready1),
      .tx_data      (tx_data1),
      .tx_start     (tx_start1),
      .busy         (busy1),
      .frame_done   (done1),
      .seq          (seq1),
      .drop_count   (drop1)
   );

   gyro_frame_tx #(.DECIM(3)) u_dut3 (
      .GCLK         (GCLK),
      .RST          (RST),
      .enable       (enable),
      .sample_valid (sample_valid),
      .x_axis_data  (x),
      .y_axis_data  (y),
      .z_axis_data  (z),
      .temp_data    (t),
      .tx_ready     (tx_ready3),
      .tx_data      (tx_data3),
      .tx_start     (tx_start3),
      .busy         (busy3),
      .frame_done   (done3),
      .seq          (seq3),
      .drop_count   (drop3)
   );

   // UART model: ready drops the cycle after start, returns N_BUSY cycles later.
   always @(posedge GCLK) begin
      if (tx_start1) bc1 <= N_BUSY;
      else if (bc1 > 0) bc1 <= bc1 - 1;
      if (tx_start3) bc3 <= N_BUSY;
      else if (bc3 > 0) bc3 <= bc3 - 1;
   end

   assign tx_ready1 = (bc1 == 0) && !hold1;
   assign tx_ready3 = (bc3 == 0);

   always @(negedge GCLK) begin
      if (tx_start1) begin
         cap.push_back(tx_data1);
         n_start <= n_start + 1;
      end
      if (done1) n_done <= n_done + 1;
      if (done3) n_done3 <= n_done3 + 1;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse(input logic [15:0] xv, input logic [15:0] yv,
                        input logic [15:0] zv, input logic [15:0] tv);
      @(negedge GCLK);
      x = xv;
      y = yv;
      z = zv;
      t = tv;
      sample_valid = 1'b1;
      @(negedge GCLK);
      sample_valid = 1'b0;
   endtask

   task automatic wait_done(input string tag);
      int  d0;
      bit  ok;
      d0 = n_done;
      ok = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge GCLK);
         if (n_done > d0) begin
            ok = 1'b1;
            break;
         end
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   task automatic wait_bytes(input string tag, input int n);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 1000; i++) begin
         @(negedge GCLK);
         if (cap.size() >= n) begin
            ok = 1'b1;
            break;
         end
      end
      check(tag, 32'(ok), 32'd1);
   endtask

   task automatic check_frame(input string tag, input logic [7:0] sq,
                              input logic [15:0] xv, input logic [15:0] yv,
                              input logic [15:0] zv, input logic [15:0] tv);
      logic [7:0] e[$];
      logic [7:0] s;
      e = '{8'hA5, 8'h5A, sq, xv[7:0], xv[15:8], yv[7:0], yv[15:8],
            zv[7:0], zv[15:8]};
`ifdef GYRO_FRAME_TEMP_EN
      e.push_back(tv[7:0]);
      e.push_back(tv[15:8]);
`else
      if (tv[0] === 1'bx) e.push_back(8'h00);
`endif
      s = 8'h00;
      for (int i = 2; i < e.size(); i++) s = s + e[i];
      e.push_back(s);
      check({tag, " len"}, 32'(cap.size()), 32'(e.size()));
      for (int i = 0; i < e.size() && i < cap.size(); i++)
         check($sformatf("%s byte%0d", tag, i), 32'(cap[i]), 32'(e[i]));
   endtask

   initial begin
      int d3;
      int s0;

      // Reset state
      repeat (2) @(negedge GCLK);
      check("rst tx_start", 32'(tx_start1), 32'd0);
      check("rst busy", 32'(busy1), 32'd0);
      check("rst seq", 32'(seq1), 32'd0);
      check("rst drop", 32'(drop1), 32'd0);
      check("rst tx_data", 32'(tx_data1), 32'd0);
      check("rst frame_done", 32'(done1), 32'd0);
      RST = 1'b0;
      enable = 1'b1;

      // Single frame
      cap.delete();
      pulse(16'h1234, 16'hABCD, 16'h0001, 16'h0000);
      check("t2 busy", 32'(busy1), 32'd1);
      wait_done("t2 done");
      check_frame("t2", 8'h00, 16'h1234, 16'hABCD, 16'h0001, 16'h0000);
`ifdef GYRO_FRAME_TEMP_EN
      check("t2 chk", 32'(cap[11]), 32'hBF);
`else
      check("t2 chk", 32'(cap[9]), 32'hBF);
`endif
      check("t2 done count", 32'(n_done), 32'd1);
      check("t2 seq", 32'(seq1), 32'd1);

      // Drop while busy
      cap.delete();
      pulse(16'h1111, 16'h2222, 16'h3333, 16'h0000);
      repeat (2) @(negedge GCLK);
      pulse(16'h4444, 16'h5555, 16'h6666, 16'h0000);
      check("t3 drop", 32'(drop1), 32'd1);
      wait_done("t3 done");
      check_frame("t3", 8'h01, 16'h1111, 16'h2222, 16'h3333, 16'h0000);
      check("t3 seq", 32'(seq1), 32'd2);

      // Decimation by 3
      RST = 1'b1;
      repeat (2) @(negedge GCLK);
      RST = 1'b0;
      check("t4 rst drop", 32'(drop1), 32'd0);
      d3 = n_done3;
      for (int p = 1; p <= 7; p++) begin
         pulse(16'(p), 16'h0000, 16'h0000, 16'h0000);
         check($sformatf("t4 busy3 p%0d", p), 32'(busy3), 32'(p % 3 == 0));
         repeat (150) @(negedge GCLK);
      end
      check("t4 seq3", 32'(seq3), 32'd2);
      check("t4 frames3", 32'(n_done3 - d3), 32'd2);
      check("t4 seq1", 32'(seq1), 32'd7);

      // enable low: nothing starts, decimator holds
      enable = 1'b0;
      pulse(16'h0000, 16'h0000, 16'h0000, 16'h0000);
      check("t4 en0 busy1", 32'(busy1), 32'd0);
      check("t4 en0 busy3", 32'(busy3), 32'd0);
      enable = 1'b1;
      pulse(16'h0000, 16'h0000, 16'h0000, 16'h0000);
      check("t4 hold busy3 a", 32'(busy3), 32'd0);
      repeat (150) @(negedge GCLK);
      pulse(16'h0000, 16'h0000, 16'h0000, 16'h0000);
      check("t4 hold busy3 b", 32'(busy3), 32'd1);
      repeat (150) @(negedge GCLK);
      check("t4 seq1 b", 32'(seq1), 32'd9);

      // Stall before byte index 4
      cap.delete();
      pulse(16'hBEEF, 16'h0102, 16'hFF00, 16'h1234);
      wait_bytes("t5 reach4", 4);
      hold1 = 1'b1;
      @(negedge GCLK);
      s0 = n_start;
      repeat (50) @(negedge GCLK);
      check("t5 no start", 32'(n_start), 32'(s0));
      check("t5 data held", 32'(tx_data1), 32'hEF);
      check("t5 busy", 32'(busy1), 32'd1);
      hold1 = 1'b0;
      wait_done("t5 done");
      check_frame("t5", 8'h09, 16'hBEEF, 16'h0102, 16'hFF00, 16'h1234);

      // Reset mid-frame with a byte in flight
      cap.delete();
      pulse(16'h5678, 16'h9ABC, 16'hDEF0, 16'h0F0F);
      wait_bytes("t6 reach5", 5);
      hold1 = 1'b1;
      RST = 1'b1;
      repeat (2) @(negedge GCLK);
      check("t6 rst busy", 32'(busy1), 32'd0);
      check("t6 rst seq", 32'(seq1), 32'd0);
      check("t6 rst tx_data", 32'(tx_data1), 32'd0);
      check("t6 rst tx_start", 32'(tx_start1), 32'd0);
      RST = 1'b0;
      cap.delete();
      pulse(16'h00FF, 16'h0F00, 16'h8001, 16'h7FFE);
      check("t6 busy", 32'(busy1), 32'd1);
      s0 = n_start;
      repeat (10) @(negedge GCLK);
      check("t6 wait ready", 32'(n_start), 32'(s0));
      hold1 = 1'b0;
      wait_done("t6 done");
      check_frame("t6", 8'h00, 16'h00FF, 16'h0F00, 16'h8001, 16'h7FFE);

      // Sequence wrap
      for (int i = 0; i < 254; i++) begin
         pulse(16'(i), 16'h0000, 16'h0000, 16'h0000);
         wait_done("t6 wrap done");
      end
      check("t6 seq ff", 32'(seq1), 32'hFF);
      cap.delete();
      pulse(16'hCAFE, 16'h0000, 16'h0000, 16'h0000);
      wait_done("t6 last done");
      check_frame("t6 last", 8'hFF, 16'hCAFE, 16'h0000, 16'h0000, 16'h0000);
      check("t6 seq wrap", 32'(seq1), 32'h00);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
